// File: rtl/mrp_tx_noc_out_mc_pkg.sv
// Shared types for the multi-channel MRP TX noc0 egress: FSM states, flit layouts,
// field widths and the payload flit-count helper.
package mrp_tx_noc_out_mc_pkg;

    localparam int XY_W       = 8;
    localparam int MSG_LEN_W  = 16;
    localparam int MSG_TYPE_W = 8;
    localparam int IP_W       = 32;
    localparam int PORT_W     = 16;
    localparam int LEN_W      = 16;
    localparam int SEL_W      = 8;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_HDR,
        ST_META,
        ST_DATA
    } state_e;

    // Field layouts; the top zero-extends them to the flit width, so the upper bits are padding.
    typedef struct packed {
        logic [XY_W-1:0]       src_y;
        logic [XY_W-1:0]       src_x;
        logic [MSG_TYPE_W-1:0] msg_type;
        logic [MSG_LEN_W-1:0]  msg_len;
        logic [XY_W-1:0]       dst_y;
        logic [XY_W-1:0]       dst_x;
    } mrp_noc_hdr_flit;

    typedef struct packed {
        logic [SEL_W-1:0]  sel;
        logic [LEN_W-1:0]  len;
        logic [PORT_W-1:0] dst_port;
        logic [PORT_W-1:0] src_port;
        logic [IP_W-1:0]   dst_ip;
        logic [IP_W-1:0]   src_ip;
    } mrp_noc_meta_flit;

    function automatic logic [16:0] flits_for_len(input logic [LEN_W-1:0] len, input int unsigned bytes);
        logic [16:0] sum;
        sum = {1'b0, len} + 17'(bytes - 1);
        return sum / 17'(bytes);
    endfunction

endpackage

// File: rtl/mrp_tx_noc_out_mc_if.sv
// Engine-array and noc0 handshake bundle of the MRP TX egress; master is the egress block.
interface mrp_tx_noc_out_mc_if #(
    parameter int NUM_CHANNELS = 2,
    parameter int NOC_DATA_W   = 512,
    parameter int PAD_W        = $clog2(NOC_DATA_W / 8)
);
    logic                               mrp_tx_out_noc0_vrtoc_val;
    logic [NOC_DATA_W-1:0]              mrp_tx_out_noc0_vrtoc_data;
    logic                               noc0_vrtoc_mrp_tx_out_rdy;
    logic [NUM_CHANNELS-1:0]            tx_meta_val;
    logic [NUM_CHANNELS*32-1:0]         tx_src_ip;
    logic [NUM_CHANNELS*32-1:0]         tx_dst_ip;
    logic [NUM_CHANNELS*16-1:0]         tx_src_port;
    logic [NUM_CHANNELS*16-1:0]         tx_dst_port;
    logic [NUM_CHANNELS*16-1:0]         tx_len;
    logic [NUM_CHANNELS-1:0]            tx_meta_rdy;
    logic [NUM_CHANNELS-1:0]            tx_data_val;
    logic [NUM_CHANNELS*NOC_DATA_W-1:0] tx_data;
    logic [NUM_CHANNELS-1:0]            tx_data_last;
    logic [NUM_CHANNELS*PAD_W-1:0]      tx_data_padbytes;
    logic [NUM_CHANNELS-1:0]            tx_data_rdy;

    modport master (
        output mrp_tx_out_noc0_vrtoc_val, mrp_tx_out_noc0_vrtoc_data, tx_meta_rdy, tx_data_rdy,
        input  noc0_vrtoc_mrp_tx_out_rdy, tx_meta_val, tx_src_ip, tx_dst_ip, tx_src_port,
               tx_dst_port, tx_len, tx_data_val, tx_data, tx_data_last, tx_data_padbytes
    );

    modport slave (
        input  mrp_tx_out_noc0_vrtoc_val, mrp_tx_out_noc0_vrtoc_data, tx_meta_rdy, tx_data_rdy,
        output noc0_vrtoc_mrp_tx_out_rdy, tx_meta_val, tx_src_ip, tx_dst_ip, tx_src_port,
               tx_dst_port, tx_len, tx_data_val, tx_data, tx_data_last, tx_data_padbytes
    );
endinterface

// File: rtl/mrp_tx_rr_arb.sv
// Round-robin grant over engine requests; the pointer moves past the served channel on advance.
module mrp_tx_rr_arb #(
    parameter int NUM_CHANNELS = 2,
    parameter int CH_W         = (NUM_CHANNELS > 1) ? $clog2(NUM_CHANNELS) : 1
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [NUM_CHANNELS-1:0] req,
    input  logic                    advance,
    input  logic [CH_W-1:0]         adv_sel,
    output logic                    gnt_val,
    output logic [CH_W-1:0]         gnt
);
    logic [CH_W-1:0] ptr_q, ptr_d;

    // Scan downward so the request closest to the pointer is written last and wins.
    always_comb begin
        int idx;
        idx     = 0;
        gnt_val = 1'b0;
        gnt     = '0;
        for (int i = NUM_CHANNELS - 1; i >= 0; i--) begin
            idx = int'(ptr_q) + i;
            if (idx >= NUM_CHANNELS) idx = idx - NUM_CHANNELS;
            if (req[idx]) begin
                gnt_val = 1'b1;
                gnt     = CH_W'(idx);
            end
        end
    end

    always_comb begin
        ptr_d = ptr_q;
        if (advance) ptr_d = (adv_sel == CH_W'(NUM_CHANNELS - 1)) ? '0 : adv_sel + CH_W'(1);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) ptr_q <= '0;
        else      ptr_q <= ptr_d;
    end
endmodule

// File: rtl/mrp_tx_noc_out_mc.sv
// Multi-channel MRP TX noc0 egress: round-robin over engines, emits header, metadata,
// then len-derived payload flits while checking the engine's last/padbytes framing.
module mrp_tx_noc_out_mc
    import mrp_tx_noc_out_mc_pkg::*;
#(
    parameter logic [XY_W-1:0]       SRC_X        = '0,
    parameter logic [XY_W-1:0]       SRC_Y        = '0,
    parameter logic [XY_W-1:0]       DST_X        = '0,
    parameter logic [XY_W-1:0]       DST_Y        = '0,
    parameter int                    NUM_CHANNELS = 2,
    parameter int                    NOC_DATA_W   = 512,
    parameter logic [MSG_TYPE_W-1:0] MSG_TYPE     = 8'h0,
    localparam int CH_W  = (NUM_CHANNELS > 1) ? $clog2(NUM_CHANNELS) : 1,
    localparam int BYTES = NOC_DATA_W / 8,
    localparam int PAD_W = $clog2(BYTES)
) (
    input  logic                clk,
    input  logic                rst,
    mrp_tx_noc_out_mc_if.master io,
    output logic                err_framing,
    output logic [CH_W-1:0]     err_chan
);
    logic [NUM_CHANNELS-1:0][IP_W-1:0]       src_ip_a, dst_ip_a;
    logic [NUM_CHANNELS-1:0][PORT_W-1:0]     sport_a, dport_a;
    logic [NUM_CHANNELS-1:0][LEN_W-1:0]      len_a;
    logic [NUM_CHANNELS-1:0][NOC_DATA_W-1:0] data_a;
    logic [NUM_CHANNELS-1:0][PAD_W-1:0]      pad_a;

    assign src_ip_a = io.tx_src_ip;
    assign dst_ip_a = io.tx_dst_ip;
    assign sport_a  = io.tx_src_port;
    assign dport_a  = io.tx_dst_port;
    assign len_a    = io.tx_len;
    assign data_a   = io.tx_data;
    assign pad_a    = io.tx_data_padbytes;

    state_e             state_q, state_d;
    logic [CH_W-1:0]    sel_q, sel_d;
    logic [IP_W-1:0]    src_ip_q, src_ip_d, dst_ip_q, dst_ip_d;
    logic [PORT_W-1:0]  sport_q, sport_d, dport_q, dport_d;
    logic [LEN_W-1:0]   len_q, len_d;
    logic [16:0]        nflits_q, nflits_d, rem_q, rem_d;
    logic               err_framing_q, err_framing_d;
    logic [CH_W-1:0]    err_chan_q, err_chan_d;

    logic                    gnt_val, advance;
    logic [CH_W-1:0]         gnt;
    logic                    noc_val;
    logic [NOC_DATA_W-1:0]   noc_data;
    logic [NUM_CHANNELS-1:0] meta_rdy, data_rdy;
    logic [PAD_W-1:0]        pad_exp;
    logic                    beat_hs, final_beat;
    mrp_noc_hdr_flit         hdr;
    mrp_noc_meta_flit        meta;

    mrp_tx_rr_arb #(.NUM_CHANNELS(NUM_CHANNELS), .CH_W(CH_W)) u_arb (
        .clk     (clk),
        .rst     (rst),
        .req     (io.tx_meta_val),
        .advance (advance),
        .adv_sel (sel_q),
        .gnt_val (gnt_val),
        .gnt     (gnt)
    );

    always_comb begin
        hdr          = '0;
        hdr.dst_x    = DST_X;
        hdr.dst_y    = DST_Y;
        hdr.msg_len  = MSG_LEN_W'(nflits_q + 17'd1);
        hdr.msg_type = MSG_TYPE;
        hdr.src_x    = SRC_X;
        hdr.src_y    = SRC_Y;
        meta          = '0;
        meta.src_ip   = src_ip_q;
        meta.dst_ip   = dst_ip_q;
        meta.src_port = sport_q;
        meta.dst_port = dport_q;
        meta.len      = len_q;
        meta.sel      = SEL_W'(sel_q);
    end

    // Bytes left unused in the final beat; zero when len fills it exactly.
    assign pad_exp    = PAD_W'((BYTES - (int'(len_q) % BYTES)) % BYTES);
    assign beat_hs    = io.tx_data_val[sel_q] && io.noc0_vrtoc_mrp_tx_out_rdy;
    assign final_beat = (rem_q == 17'd1);

    always_comb begin
        state_d       = state_q;
        sel_d         = sel_q;
        src_ip_d      = src_ip_q;
        dst_ip_d      = dst_ip_q;
        sport_d       = sport_q;
        dport_d       = dport_q;
        len_d         = len_q;
        nflits_d      = nflits_q;
        rem_d         = rem_q;
        err_framing_d = err_framing_q;
        err_chan_d    = err_chan_q;
        advance       = 1'b0;
        noc_val       = 1'b0;
        noc_data      = '0;
        meta_rdy      = '0;
        data_rdy      = '0;
        case (state_q)
            ST_IDLE: if (gnt_val) begin
                meta_rdy[gnt] = 1'b1;
                sel_d         = gnt;
                src_ip_d      = src_ip_a[gnt];
                dst_ip_d      = dst_ip_a[gnt];
                sport_d       = sport_a[gnt];
                dport_d       = dport_a[gnt];
                len_d         = len_a[gnt];
                nflits_d      = flits_for_len(len_a[gnt], BYTES);
                rem_d         = nflits_d;
                state_d       = ST_HDR;
            end
            ST_HDR: begin
                noc_val  = 1'b1;
                noc_data = NOC_DATA_W'(hdr);
                if (io.noc0_vrtoc_mrp_tx_out_rdy) state_d = ST_META;
            end
            ST_META: begin
                noc_val  = 1'b1;
                noc_data = NOC_DATA_W'(meta);
                if (io.noc0_vrtoc_mrp_tx_out_rdy) begin
                    if (nflits_q != 17'd0) begin
                        state_d = ST_DATA;
                    end else begin
                        state_d = ST_IDLE;
                        advance = 1'b1;
                    end
                end
            end
            ST_DATA: begin
                noc_val         = io.tx_data_val[sel_q];
                noc_data        = data_a[sel_q];
                data_rdy[sel_q] = io.noc0_vrtoc_mrp_tx_out_rdy;
                if (beat_hs) begin
                    rem_d = rem_q - 17'd1;
                    // The beat count follows len only; framing disagreements are flagged, not obeyed.
                    if ((io.tx_data_last[sel_q] != final_beat) ||
                        (final_beat && (pad_a[sel_q] != pad_exp))) begin
                        err_framing_d = 1'b1;
                        if (!err_framing_q) err_chan_d = sel_q;
                    end
                    if (final_beat) begin
                        state_d = ST_IDLE;
                        advance = 1'b1;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q       <= ST_IDLE;
            sel_q         <= '0;
            src_ip_q      <= '0;
            dst_ip_q      <= '0;
            sport_q       <= '0;
            dport_q       <= '0;
            len_q         <= '0;
            nflits_q      <= '0;
            rem_q         <= '0;
            err_framing_q <= 1'b0;
            err_chan_q    <= '0;
        end else begin
            state_q       <= state_d;
            sel_q         <= sel_d;
            src_ip_q      <= src_ip_d;
            dst_ip_q      <= dst_ip_d;
            sport_q       <= sport_d;
            dport_q       <= dport_d;
            len_q         <= len_d;
            nflits_q      <= nflits_d;
            rem_q         <= rem_d;
            err_framing_q <= err_framing_d;
            err_chan_q    <= err_chan_d;
        end
    end

    assign io.mrp_tx_out_noc0_vrtoc_val  = noc_val;
    assign io.mrp_tx_out_noc0_vrtoc_data = noc_data;
    assign io.tx_meta_rdy                = meta_rdy;
    assign io.tx_data_rdy                = data_rdy;
    assign err_framing                   = err_framing_q;
    assign err_chan                      = err_chan_q;
endmodule

// File: tb/tb_mrp_tx_noc_out_mc.sv
// Scoreboard bench for mrp_tx_noc_out_mc: directed messages push expected flits,
// a monitor pops and compares on every noc0 handshake.
module tb_mrp_tx_noc_out_mc;
    localparam int NCH = 4;
    localparam int W   = 512;
    localparam int PW  = 6;

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic       err_framing;
    logic [1:0] err_chan;

    always #5 clk = ~clk;

    mrp_tx_noc_out_mc_if #(.NUM_CHANNELS(NCH), .NOC_DATA_W(W)) io ();

    mrp_tx_noc_out_mc #(
        .SRC_X(8'h03), .SRC_Y(8'h04), .DST_X(8'h05), .DST_Y(8'h06),
        .NUM_CHANNELS(NCH), .NOC_DATA_W(W), .MSG_TYPE(8'hA5)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .io          (io),
        .err_framing (err_framing),
        .err_chan    (err_chan)
    );

    typedef struct {
        int          ch;
        logic [15:0] len;
        int          beats;
        int          last_at;
        logic [5:0]  pad;
        logic [7:0]  tag;
    } msg_t;

    typedef struct {
        logic [W-1:0] d;
        logic         last;
        logic [5:0]   pad;
    } beat_t;

    msg_t         mq[NCH][$];
    beat_t        bq[NCH][$];
    logic [W-1:0] exp_q[$];

    int   n_chk = 0, n_pass = 0;
    int   cyc = 0;
    int   rdy_mode = 0, gap_mode = 0;
    logic [3:0] rdy_pat = 4'b1001;
    int   meta_hs_cyc = -1, first_noc_cyc = -1, last_noc_cyc = -1;
    bit   drdy_seen = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    function automatic logic [W-1:0] beat_data(input int ch, input logic [7:0] tag, input int b);
        return {16{8'(ch), tag, 16'(b)}};
    endfunction

    function automatic logic [31:0] sip(input int ch, input logic [7:0] tag);
        return {8'd10, 8'd0, 8'(ch), tag};
    endfunction

    function automatic logic [31:0] dip(input int ch, input logic [7:0] tag);
        return {8'd10, 8'd1, 8'(ch), tag};
    endfunction

    // Queue one message on engine ch; ml is the hand-computed header msg_len.
    task automatic send(input int ch, input logic [15:0] len, input int beats, input int last_at,
                        input logic [5:0] pad, input logic [15:0] ml, input logic [7:0] tag);
        msg_t m;
        logic [W-1:0] f;
        m.ch = ch; m.len = len; m.beats = beats; m.last_at = last_at; m.pad = pad; m.tag = tag;
        mq[ch].push_back(m);
        f = '0;
        f[7:0] = 8'h05; f[15:8] = 8'h06; f[31:16] = ml;
        f[39:32] = 8'hA5; f[47:40] = 8'h03; f[55:48] = 8'h04;
        exp_q.push_back(f);
        f = '0;
        f[31:0] = sip(ch, tag); f[63:32] = dip(ch, tag);
        f[79:64] = {8'h10, tag}; f[95:80] = {8'h20, tag};
        f[111:96] = len; f[119:112] = 8'(ch);
        exp_q.push_back(f);
        for (int b = 0; b < beats; b++) exp_q.push_back(beat_data(ch, tag, b));
    endtask

    function automatic bit all_idle();
        bit r;
        r = (exp_q.size() == 0);
        for (int c = 0; c < NCH; c++) if (mq[c].size() != 0 || bq[c].size() != 0) r = 0;
        return r;
    endfunction

    task automatic wait_done(input string name, input int budget);
        int n;
        n = 0;
        while (!all_idle() && n < budget) begin
            @(negedge clk);
            n++;
        end
        if (!all_idle()) begin
            n_chk++;
            $display("FAIL %s: timeout with %0d flits outstanding, required 0", name, exp_q.size());
        end
        repeat (2) @(negedge clk);
    endtask

    // NoC ready source
    initial begin
        io.noc0_vrtoc_mrp_tx_out_rdy = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            io.noc0_vrtoc_mrp_tx_out_rdy = (rdy_mode == 0) ? 1'b1 : rdy_pat[cyc % 4];
        end
    end

    // Engine array model: handshakes sampled at negedge, acted on just after posedge.
    initial begin
        logic [NCH-1:0] mhs, dhs;
        msg_t  m;
        beat_t bt;
        io.tx_meta_val = '0; io.tx_src_ip = '0; io.tx_dst_ip = '0; io.tx_src_port = '0;
        io.tx_dst_port = '0; io.tx_len = '0; io.tx_data_val = '0; io.tx_data = '0;
        io.tx_data_last = '0; io.tx_data_padbytes = '0;
        forever begin
            @(negedge clk);
            mhs = io.tx_meta_val & io.tx_meta_rdy;
            dhs = io.tx_data_val & io.tx_data_rdy;
            @(posedge clk);
            #1;
            for (int c = 0; c < NCH; c++) begin
                if (!rst) begin
                    mq[c].delete();
                    bq[c].delete();
                end else begin
                    if (mhs[c] && mq[c].size() != 0) begin
                        m = mq[c].pop_front();
                        for (int b = 0; b < m.beats; b++) begin
                            bt.d    = beat_data(c, m.tag, b);
                            bt.last = (b == m.last_at);
                            bt.pad  = (b == m.beats - 1) ? m.pad : 6'd0;
                            bq[c].push_back(bt);
                        end
                    end
                    if (dhs[c] && bq[c].size() != 0) void'(bq[c].pop_front());
                end
                io.tx_meta_val[c] = rst && (mq[c].size() != 0);
                if (mq[c].size() != 0) begin
                    io.tx_src_ip[c*32 +: 32]   = sip(c, mq[c][0].tag);
                    io.tx_dst_ip[c*32 +: 32]   = dip(c, mq[c][0].tag);
                    io.tx_src_port[c*16 +: 16] = {8'h10, mq[c][0].tag};
                    io.tx_dst_port[c*16 +: 16] = {8'h20, mq[c][0].tag};
                    io.tx_len[c*16 +: 16]      = mq[c][0].len;
                end
                io.tx_data_val[c] = rst && (bq[c].size() != 0) && !(gap_mode != 0 && (cyc % 3) == 1);
                if (bq[c].size() != 0) begin
                    io.tx_data[c*W +: W]            = bq[c][0].d;
                    io.tx_data_last[c]              = bq[c][0].last;
                    io.tx_data_padbytes[c*PW +: PW] = bq[c][0].pad;
                end else begin
                    io.tx_data[c*W +: W]            = '0;
                    io.tx_data_last[c]              = 1'b0;
                    io.tx_data_padbytes[c*PW +: PW] = '0;
                end
            end
        end
    end

    // Monitor / scoreboard
    initial begin
        bit           prev_stall;
        logic [W-1:0] prev_data, e;
        prev_stall = 0;
        prev_data  = '0;
        forever begin
            @(negedge clk);
            if (!rst) begin
                prev_stall = 0;
                continue;
            end
            if (io.tx_meta_rdy != '0) begin
                chk("meta_rdy_onehot_to_requester",
                    W'(($countones(io.tx_meta_rdy) == 1) && ((io.tx_meta_rdy & ~io.tx_meta_val) == '0)), W'(1));
                meta_hs_cyc   = cyc;
                first_noc_cyc = -1;
            end
            if (io.tx_data_rdy != '0) drdy_seen = 1;
            if (prev_stall && io.mrp_tx_out_noc0_vrtoc_val)
                chk("stall_data_stable", io.mrp_tx_out_noc0_vrtoc_data, prev_data);
            if (io.mrp_tx_out_noc0_vrtoc_val && io.noc0_vrtoc_mrp_tx_out_rdy) begin
                if (first_noc_cyc < 0) first_noc_cyc = cyc;
                last_noc_cyc = cyc;
                if (exp_q.size() == 0) begin
                    n_chk++;
                    $display("FAIL unexpected_flit: got %0h expected none", io.mrp_tx_out_noc0_vrtoc_data);
                end else begin
                    e = exp_q.pop_front();
                    chk("flit", io.mrp_tx_out_noc0_vrtoc_data, e);
                end
            end
            prev_stall = io.mrp_tx_out_noc0_vrtoc_val && !io.noc0_vrtoc_mrp_tx_out_rdy;
            prev_data  = io.mrp_tx_out_noc0_vrtoc_data;
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish, %0d/%0d", n_pass, n_chk);
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        repeat (3) @(posedge clk);
        #2;
        chk("rst_val", W'(io.mrp_tx_out_noc0_vrtoc_val), W'(0));
        chk("rst_data", io.mrp_tx_out_noc0_vrtoc_data, '0);
        chk("rst_meta_rdy", W'(io.tx_meta_rdy), W'(0));
        chk("rst_data_rdy", W'(io.tx_data_rdy), W'(0));
        chk("rst_err_framing", W'(err_framing), W'(0));
        chk("rst_err_chan", W'(err_chan), W'(0));
        @(posedge clk);
        #2 rst = 1'b1;
        repeat (2) @(negedge clk);

        // ch0, len 130: 3 data flits, final pad 62, 6-cycle message
        send(0, 16'd130, 3, 2, 6'd62, 16'd4, 8'h01);
        wait_done("len130", 100);
        chk("hdr_latency", W'(first_noc_cyc - meta_hs_cyc), W'(1));
        chk("msg_cycles", W'(last_noc_cyc - meta_hs_cyc), W'(5));
        chk("len130_err", W'(err_framing), W'(0));

        // ch3, len 0: header+meta only, pointer wraps to 0
        drdy_seen = 0;
        send(3, 16'd0, 0, -1, 6'd0, 16'd1, 8'h02);
        wait_done("len0", 100);
        chk("len0_no_data_rdy", W'(drdy_seen), W'(0));

        // all four channels requesting: grants must rotate 0..3 twice
        for (int r = 0; r < 2; r++)
            for (int c = 0; c < NCH; c++)
                send(c, 16'd64, 1, 0, 6'd0, 16'd2, 8'(8'h10 + r * 4 + c));
        wait_done("rotate", 400);

        // stalls: NoC ready 1,0,0,1 and engine data gaps
        rdy_mode = 1;
        gap_mode = 1;
        send(0, 16'd65, 2, 1, 6'd63, 16'd3, 8'h20);
        send(1, 16'd200, 4, 3, 6'd56, 16'd5, 8'h21);
        wait_done("stall", 600);
        rdy_mode = 0;
        gap_mode = 0;
        repeat (2) @(negedge clk);
        chk("stall_err", W'(err_framing), W'(0));

        // ch2 early last: both beats still consumed, error latched on channel 2
        send(2, 16'd128, 2, 0, 6'd0, 16'd3, 8'h30);
        wait_done("early_last", 100);
        chk("early_last_err", W'(err_framing), W'(1));
        chk("early_last_chan", W'(err_chan), W'(2));
        send(1, 16'd64, 1, 0, 6'd0, 16'd2, 8'h31);
        wait_done("after_err", 100);
        chk("sticky_err", W'(err_framing), W'(1));
        chk("sticky_chan", W'(err_chan), W'(2));

        // park the pointer at 3, then reset in the middle of a data burst
        send(2, 16'd64, 1, 0, 6'd0, 16'd2, 8'h40);
        wait_done("ptr3", 100);
        send(1, 16'd256, 4, 3, 6'd0, 16'd5, 8'h41);
        n = 0;
        while (n < 100 && (io.tx_data_val & io.tx_data_rdy) == '0) begin
            @(negedge clk);
            n++;
        end
        chk("reach_data_beat", W'((io.tx_data_val & io.tx_data_rdy) != '0), W'(1));
        @(posedge clk);
        #3 rst = 1'b0;
        #1;
        chk("midrst_val", W'(io.mrp_tx_out_noc0_vrtoc_val), W'(0));
        chk("midrst_meta_rdy", W'(io.tx_meta_rdy), W'(0));
        chk("midrst_data_rdy", W'(io.tx_data_rdy), W'(0));
        chk("midrst_err", W'(err_framing), W'(0));
        exp_q.delete();
        repeat (3) @(posedge clk);
        #2 rst = 1'b1;
        send(0, 16'd64, 1, 0, 6'd0, 16'd2, 8'h50);
        send(3, 16'd64, 1, 0, 6'd0, 16'd2, 8'h51);
        wait_done("post_rst", 100);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
